// File: rtl/reg_xfer_pkg.sv
// Opcodes shared by the register bank and its sequencing controller.
package reg_xfer_pkg;
  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_LOAD = 3'd1;
  localparam logic [2:0] OP_MOVE = 3'd2;
  localparam logic [2:0] OP_SHL  = 3'd3;
  localparam logic [2:0] OP_SHR  = 3'd4;
  localparam logic [2:0] OP_ROL  = 3'd5;
  localparam logic [2:0] OP_ROR  = 3'd6;
  localparam logic [2:0] OP_CLR  = 3'd7;
endpackage

// File: rtl/reg_transfer_cell.sv
// One WIDTH-bit storage register with write enable.
module reg_transfer_cell #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             i_we,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH-1:0] r_q;

  always_ff @(posedge CLK) begin
    if (RST)       r_q <= '0;
    else if (i_we) r_q <= i_d;
  end

  assign o_q = r_q;
endmodule

// File: rtl/reg_transfer_bank.sv
// Register bank with opcode-driven load/move/shift/rotate/clear unit.
module reg_transfer_bank
  import reg_xfer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREGS = 4,
  localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [2:0]       OP,
  input  logic [AW-1:0]    DST,
  input  logic [AW-1:0]    SRC,
  input  logic [WIDTH-1:0] D,
  input  logic             SIN,
  input  logic [AW-1:0]    RSEL,
  output logic [WIDTH-1:0] Q,
  output logic             SOUT,
  output logic             ACK,
  output logic             ERR
);
  localparam logic [AW:0] LIM = (AW+1)'(NREGS);

  logic [WIDTH-1:0] w_r [NREGS];
  logic [WIDTH-1:0] w_cur;
  logic [WIDTH-1:0] w_src;
  logic [WIDTH-1:0] w_nxt;
  logic [NREGS-1:0] w_we;
  logic             w_dst_ok;
  logic             w_src_ok;
  logic             w_valid;
  logic             w_err;
  logic             w_shift;
  logic             w_sbit;
  logic             r_sout;
  logic             r_ack;
  logic             r_err;

  assign w_dst_ok = {1'b0, DST} < LIM;
  assign w_src_ok = {1'b0, SRC} < LIM;
  assign w_err    = (OP != OP_NOP) &&
                    (!w_dst_ok || (OP == OP_MOVE && !w_src_ok));
  assign w_valid  = (OP != OP_NOP) && !w_err;

  always_comb begin
    w_cur = '0;
    w_src = '0;
    Q     = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (DST == AW'(i))  w_cur = w_r[i];
      if (SRC == AW'(i))  w_src = w_r[i];
      if (RSEL == AW'(i)) Q     = w_r[i];
    end
  end

  always_comb begin
    w_nxt   = w_cur;
    w_shift = 1'b0;
    w_sbit  = r_sout;
    case (OP)
      OP_LOAD: w_nxt = D;
      OP_MOVE: w_nxt = w_src;
      OP_SHL: begin
        w_nxt   = {w_cur[WIDTH-2:0], SIN};
        w_shift = 1'b1;
        w_sbit  = w_cur[WIDTH-1];
      end
      OP_SHR: begin
        w_nxt   = {SIN, w_cur[WIDTH-1:1]};
        w_shift = 1'b1;
        w_sbit  = w_cur[0];
      end
      OP_ROL: begin
        w_nxt   = {w_cur[WIDTH-2:0], w_cur[WIDTH-1]};
        w_shift = 1'b1;
        w_sbit  = w_cur[WIDTH-1];
      end
      OP_ROR: begin
        w_nxt   = {w_cur[0], w_cur[WIDTH-1:1]};
        w_shift = 1'b1;
        w_sbit  = w_cur[0];
      end
      OP_CLR:  w_nxt = '0;
      default: w_nxt = w_cur;
    endcase
  end

  always_comb begin
    w_we = '0;
    for (int i = 0; i < NREGS; i++)
      w_we[i] = w_valid && (DST == AW'(i));
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_cell
    reg_transfer_cell #(.WIDTH(WIDTH)) u_cell (
      .CLK  (CLK),
      .RST  (RST),
      .i_we (w_we[g]),
      .i_d  (w_nxt),
      .o_q  (w_r[g])
    );
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sout <= 1'b0;
      r_ack  <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      if (w_valid && w_shift) r_sout <= w_sbit;
      r_ack <= w_valid;
      r_err <= w_err;
    end
  end

  assign SOUT = r_sout;
  assign ACK  = r_ack;
  assign ERR  = r_err;
endmodule

// File: tb/tb_reg_transfer_bank.sv
// Scoreboard bench: 4-register bank plus a 3-register bank for range errors.
module tb_reg_transfer_bank;
  import reg_xfer_pkg::*;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, sin;
  logic [2:0] op;
  logic [1:0] dst, src, rsel;
  logic [7:0] d, q;
  logic       sout, ack, err;

  logic       rst3, sin3;
  logic [2:0] op3;
  logic [1:0] dst3, src3, rsel3;
  logic [7:0] d3, q3;
  logic       sout3, ack3, err3;

  reg_transfer_bank #(.WIDTH(8), .NREGS(4)) u_dut (
    .CLK(clk), .RST(rst), .OP(op), .DST(dst), .SRC(src), .D(d),
    .SIN(sin), .RSEL(rsel), .Q(q), .SOUT(sout), .ACK(ack), .ERR(err)
  );

  reg_transfer_bank #(.WIDTH(8), .NREGS(3)) u_dut3 (
    .CLK(clk), .RST(rst3), .OP(op3), .DST(dst3), .SRC(src3), .D(d3),
    .SIN(sin3), .RSEL(rsel3), .Q(q3), .SOUT(sout3), .ACK(ack3), .ERR(err3)
  );

  typedef struct {
    logic ack;
    logic err;
    logic sout;
  } exp_t;

  exp_t       sb[$];
  exp_t       e;
  logic [7:0] m [4];
  logic       m_sout;
  int         total = 0;
  int         bad   = 0;

  function automatic void model_step(input logic r, input logic [2:0] o,
                                     input logic [1:0] ds, input logic [1:0] sr,
                                     input logic [7:0] dd, input logic si);
    exp_t x;
    logic [7:0] c;
    if (r) begin
      for (int i = 0; i < 4; i++) m[i] = 8'h00;
      m_sout = 1'b0;
      x = '{ack: 1'b0, err: 1'b0, sout: 1'b0};
    end else begin
      c = m[ds];
      case (o)
        OP_LOAD: m[ds] = dd;
        OP_MOVE: m[ds] = m[sr];
        OP_SHL:  begin m[ds] = {c[6:0], si};   m_sout = c[7]; end
        OP_SHR:  begin m[ds] = {si, c[7:1]};   m_sout = c[0]; end
        OP_ROL:  begin m[ds] = {c[6:0], c[7]}; m_sout = c[7]; end
        OP_ROR:  begin m[ds] = {c[0], c[7:1]}; m_sout = c[0]; end
        OP_CLR:  m[ds] = 8'h00;
        default: ;
      endcase
      x = '{ack: (o != OP_NOP), err: 1'b0, sout: m_sout};
    end
    sb.push_back(x);
  endfunction

  task automatic drive(input logic r, input logic [2:0] o, input logic [1:0] ds,
                       input logic [1:0] sr, input logic [7:0] dd, input logic si);
    @(negedge clk);
    rst = r; op = o; dst = ds; src = sr; d = dd; sin = si;
    model_step(r, o, ds, sr, dd, si);
  endtask

  task automatic edge_pop();
    @(posedge clk);
    #1;
    e = sb.pop_front();
  endtask

  task automatic drive3(input logic [2:0] o, input logic [1:0] ds,
                        input logic [1:0] sr, input logic [7:0] dd);
    @(negedge clk);
    rst3 = 1'b0; op3 = o; dst3 = ds; src3 = sr; d3 = dd; sin3 = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, OP_LOAD, 2'd0, 2'd0, 8'hFF, 1'b1);
    edge_pop();
    total++;
    if ({ack, err, sout} !== {e.ack, e.err, e.sout}) begin
      bad++;
      $display("FAIL reset_flags got=%b want=%b", {ack, err, sout},
               {e.ack, e.err, e.sout});
    end
    for (int i = 0; i < 4; i++) begin
      rsel = 2'(i);
      #1;
      total++;
      if (q !== 8'h00) begin
        bad++;
        $display("FAIL reset_q%0d got=%h want=00", i, q);
      end
    end
  endtask

  task automatic test_move();
    drive(1'b0, OP_LOAD, 2'd2, 2'd0, 8'hA5, 1'b0);
    edge_pop();
    rsel = 2'd2;
    #1;
    total++;
    if (ack !== e.ack || q !== 8'hA5) begin
      bad++;
      $display("FAIL load got ack=%b q=%h want ack=%b q=a5", ack, q, e.ack);
    end
    drive(1'b0, OP_MOVE, 2'd0, 2'd2, 8'h00, 1'b0);
    edge_pop();
    rsel = 2'd0;
    #1;
    total++;
    if (ack !== e.ack || q !== 8'hA5) begin
      bad++;
      $display("FAIL move got ack=%b q=%h want ack=%b q=a5", ack, q, e.ack);
    end
    rsel = 2'd2;
    #1;
    total++;
    if (q !== 8'hA5) begin
      bad++;
      $display("FAIL move_src got=%h want=a5", q);
    end
    drive(1'b0, OP_MOVE, 2'd2, 2'd2, 8'h00, 1'b0);
    edge_pop();
    total++;
    if (ack !== 1'b1 || q !== 8'hA5) begin
      bad++;
      $display("FAIL move_self got ack=%b q=%h want ack=1 q=a5", ack, q);
    end
  endtask

  task automatic test_shift();
    logic [2:0] ops  [5];
    logic       sins [5];
    logic [7:0] want [5];
    logic       wso  [5];
    ops  = '{OP_LOAD, OP_SHL, OP_ROR, OP_SHR, OP_ROL};
    sins = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    want = '{8'h81, 8'h02, 8'h01, 8'h80, 8'h01};
    wso  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    rsel = 2'd1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, ops[i], 2'd1, 2'd0, 8'h81, sins[i]);
      edge_pop();
      total++;
      if (q !== want[i] || ack !== e.ack || (i > 0 && sout !== wso[i])
          || sout !== e.sout) begin
        bad++;
        $display("FAIL shift%0d got q=%h sout=%b ack=%b want q=%h sout=%b ack=%b",
                 i, q, sout, ack, want[i], e.sout, e.ack);
      end
    end
    drive(1'b0, OP_LOAD, 2'd3, 2'd0, 8'h7E, 1'b0);
    edge_pop();
    total++;
    if (sout !== e.sout) begin
      bad++;
      $display("FAIL sout_hold got=%b want=%b", sout, e.sout);
    end
  endtask

  task automatic test_out_of_range();
    drive3(OP_LOAD, 2'd0, 2'd0, 8'h11);
    drive3(OP_LOAD, 2'd1, 2'd0, 8'h22);
    drive3(OP_LOAD, 2'd2, 2'd0, 8'h33);
    total++;
    if (ack3 !== 1'b1 || err3 !== 1'b0) begin
      bad++;
      $display("FAIL n3_load got ack=%b err=%b want ack=1 err=0", ack3, err3);
    end
    drive3(OP_LOAD, 2'd3, 2'd0, 8'hFF);
    total++;
    if (ack3 !== 1'b0 || err3 !== 1'b1) begin
      bad++;
      $display("FAIL n3_dst got ack=%b err=%b want ack=0 err=1", ack3, err3);
    end
    drive3(OP_MOVE, 2'd0, 2'd3, 8'h00);
    total++;
    if (ack3 !== 1'b0 || err3 !== 1'b1) begin
      bad++;
      $display("FAIL n3_src got ack=%b err=%b want ack=0 err=1", ack3, err3);
    end
    for (int i = 0; i < 3; i++) begin
      rsel3 = 2'(i);
      #1;
      total++;
      if (q3 !== 8'(8'h11 * (i + 1))) begin
        bad++;
        $display("FAIL n3_hold%0d got=%h want=%h", i, q3, 8'(8'h11 * (i + 1)));
      end
    end
    rsel3 = 2'd3;
    #1;
    total++;
    if (q3 !== 8'h00) begin
      bad++;
      $display("FAIL n3_rsel got=%h want=00", q3);
    end
    drive3(OP_NOP, 2'd3, 2'd3, 8'h00);
    total++;
    if (ack3 !== 1'b0 || err3 !== 1'b0) begin
      bad++;
      $display("FAIL n3_nop got ack=%b err=%b want ack=0 err=0", ack3, err3);
    end
  endtask

  task automatic test_reset_override();
    drive(1'b1, OP_LOAD, 2'd1, 2'd0, 8'h3C, 1'b0);
    edge_pop();
    rsel = 2'd1;
    #1;
    total++;
    if (q !== 8'h00 || ack !== e.ack || sout !== 1'b0) begin
      bad++;
      $display("FAIL rst_override got q=%h ack=%b sout=%b want q=00 ack=0 sout=0",
               q, ack, sout);
    end
    drive(1'b0, OP_CLR, 2'd1, 2'd0, 8'h00, 1'b0);
    edge_pop();
    total++;
    if (q !== 8'h00 || ack !== e.ack) begin
      bad++;
      $display("FAIL clr got q=%h ack=%b want q=00 ack=%b", q, ack, e.ack);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, OP_LOAD, 2'(i), 2'd0, 8'(i + 1), 1'b0);
      edge_pop();
      total++;
      if (ack !== e.ack || err !== e.err) begin
        bad++;
        $display("FAIL b2b_ack%0d got ack=%b err=%b want ack=%b err=%b",
                 i, ack, err, e.ack, e.err);
      end
    end
    for (int i = 0; i < 4; i++) begin
      rsel = 2'(i);
      #1;
      total++;
      if (q !== 8'(i + 1)) begin
        bad++;
        $display("FAIL b2b_q%0d got=%h want=%h", i, q, 8'(i + 1));
      end
    end
    drive(1'b0, OP_NOP, 2'd0, 2'd0, 8'hEE, 1'b0);
    edge_pop();
    rsel = 2'd0;
    #1;
    total++;
    if (ack !== e.ack || q !== 8'h01) begin
      bad++;
      $display("FAIL nop got ack=%b q=%h want ack=%b q=01", ack, q, e.ack);
    end
  endtask

  initial begin
    rst = 1'b1; op = OP_NOP; dst = '0; src = '0; d = '0; sin = 1'b0; rsel = '0;
    rst3 = 1'b1; op3 = OP_NOP; dst3 = '0; src3 = '0; d3 = '0; sin3 = 1'b0;
    rsel3 = '0;
    for (int i = 0; i < 4; i++) m[i] = 8'h00;
    m_sout = 1'b0;
    test_reset();
    test_move();
    test_shift();
    test_out_of_range();
    test_reset_override();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
